lat_mem_port_arbiter: RTL and testbench

- Round-robin arbiter that shares one port of the latency-based multi-bank memory between two requesters (R0, R1).
- Issues one command per cycle to the memory port and tracks in-flight reads through a READ_LATENCY-deep tag pipeline, so each read result is steered back to the requester that issued it.
- Stalls any read whose address matches a write not yet committed (write is committed WRITE_LATENCY cycles after issue), preventing stale read-after-write.

---
 rtl/lat_mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_lat_mem_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lat_mem_port_arbiter.sv
// lat_mem_port_arbiter: round-robin share of one latency-based memory port
// between two requesters. Registered command issue, write-hazard tracking so
// reads never see stale data, and a read tag pipeline that steers each result
// back to the requester that issued it.
// Optional: define LAT_MEM_ARB_STATS_EN to add grant/stall counters.
module lat_mem_port_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 3,
  parameter int WRITE_LATENCY = 4,
  parameter int READ_LATENCY  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid0,
  input  logic                  i_valid1,
  input  logic                  i_we0,
  input  logic                  i_we1,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_wdata0,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  output logic                  o_ready0,
  output logic                  o_ready1,
  output logic                  o_rvalid0,
  output logic                  o_rvalid1,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_din,
  input  logic [DATA_WIDTH-1:0] i_mem_dout,
  output logic                  o_busy
`ifdef LAT_MEM_ARB_STATS_EN
  ,
  output logic [15:0]           o_grant_cnt0,
  output logic [15:0]           o_grant_cnt1,
  output logic [15:0]           o_stall_cnt
`endif
);

  // Only the youngest WRITE_LATENCY-1 tracker entries need an address: the
  // oldest entry's write lands at the end of its cycle, before any read
  // granted in that cycle can reach the port.
  localparam int TRK_AW = (WRITE_LATENCY > 1) ? WRITE_LATENCY - 1 : 1;

  logic                                 rr_ptr;
  logic [WRITE_LATENCY-1:0]             trk_vld;
  logic [TRK_AW-1:0][ADDR_WIDTH-1:0]    trk_addr;
  logic [READ_LATENCY-1:0]              tag_vld;
  logic [READ_LATENCY-1:0]              tag_id;
  logic                                 mem_id;
  logic                                 hz0, hz1, elig0, elig1, gnt0, gnt1, gnt;
  logic                                 g_we;
  logic [ADDR_WIDTH-1:0]                g_addr;
  logic [DATA_WIDTH-1:0]                g_din;

  // Read hazard: uncommitted tracked write, or the other side presenting a
  // write to the same address this cycle (that write wins the slot).
  always_comb begin
    hz0 = i_valid1 && i_we1 && (i_addr1 == i_addr0);
    hz1 = i_valid0 && i_we0 && (i_addr0 == i_addr1);
    for (int i = 0; i < WRITE_LATENCY - 1; i++) begin
      if (trk_vld[i] && (trk_addr[i] == i_addr0)) hz0 = 1'b1;
      if (trk_vld[i] && (trk_addr[i] == i_addr1)) hz1 = 1'b1;
    end
    hz0 = hz0 && i_valid0 && !i_we0;
    hz1 = hz1 && i_valid1 && !i_we1;
  end

  // Round-robin grant among eligible requesters; nothing granted in reset.
  always_comb begin
    elig0  = i_rst_n && i_valid0 && !hz0;
    elig1  = i_rst_n && i_valid1 && !hz1;
    gnt0   = elig0 && (!elig1 || !rr_ptr);
    gnt1   = elig1 && (!elig0 || rr_ptr);
    gnt    = gnt0 || gnt1;
    g_we   = gnt1 ? i_we1    : i_we0;
    g_addr = gnt1 ? i_addr1  : i_addr0;
    g_din  = gnt1 ? i_wdata1 : i_wdata0;
  end

  assign o_ready0 = gnt0;
  assign o_ready1 = gnt1;

  // Pointer moves away from whoever was just served.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  rr_ptr <= 1'b0;
    else if (gnt0) rr_ptr <= 1'b1;
    else if (gnt1) rr_ptr <= 1'b0;
  end

  // Registered memory command; addr/din hold when idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_en   <= 1'b0;
      o_mem_we   <= 1'b0;
      o_mem_addr <= '0;
      o_mem_din  <= '0;
      mem_id     <= 1'b0;
    end else begin
      o_mem_en <= gnt;
      o_mem_we <= gnt && g_we;
      if (gnt) begin
        o_mem_addr <= g_addr;
        o_mem_din  <= g_din;
        mem_id     <= gnt1;
      end
    end
  end

  // Write tracker: entry 0 holds the write now at the port, then ages out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      trk_vld  <= '0;
      trk_addr <= '0;
    end else begin
      trk_vld[0]  <= gnt && g_we;
      trk_addr[0] <= g_addr;
      for (int i = 1; i < WRITE_LATENCY; i++) trk_vld[i] <= trk_vld[i-1];
      for (int i = 1; i < TRK_AW; i++) trk_addr[i] <= trk_addr[i-1];
    end
  end

  // Read tag pipeline: tail lines up with i_mem_dout for that read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= o_mem_en && !o_mem_we;
      tag_id[0]  <= mem_id;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  assign o_rvalid0 = tag_vld[READ_LATENCY-1] && !tag_id[READ_LATENCY-1];
  assign o_rvalid1 = tag_vld[READ_LATENCY-1] &&  tag_id[READ_LATENCY-1];
  assign o_rdata   = tag_vld[READ_LATENCY-1] ? i_mem_dout : '0;
  assign o_busy    = (|trk_vld) || (|tag_vld);

`ifdef LAT_MEM_ARB_STATS_EN
  // Saturating grant and hazard-stall counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_grant_cnt0 <= '0;
      o_grant_cnt1 <= '0;
      o_stall_cnt  <= '0;
    end else begin
      if (gnt0 && o_grant_cnt0 != 16'hFFFF) o_grant_cnt0 <= o_grant_cnt0 + 16'd1;
      if (gnt1 && o_grant_cnt1 != 16'hFFFF) o_grant_cnt1 <= o_grant_cnt1 + 16'd1;
      if ((hz0 || hz1) && o_stall_cnt != 16'hFFFF) o_stall_cnt <= o_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lat_mem_port_arbiter.sv
// tb_lat_mem_port_arbiter: directed + random stimulus against a
// transaction-level reference (architectural memory updated in grant order,
// latency-delayed physical memory driving i_mem_dout).
module tb_lat_mem_port_arbiter;
  localparam int DW = 8, AW = 3, WL = 4, RL = 2;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          rv [2];
  logic          rwe [2];
  logic [AW-1:0] ra [2];
  logic [DW-1:0] rd [2];
  logic          o_ready0, o_ready1, o_rvalid0, o_rvalid1;
  logic [DW-1:0] o_rdata, o_mem_din, i_mem_dout;
  logic          o_mem_en, o_mem_we, o_busy;
  logic [AW-1:0] o_mem_addr;
`ifdef LAT_MEM_ARB_STATS_EN
  logic [15:0]   gc0, gc1, sc;
`endif

  always #5 i_clk = ~i_clk;

  lat_mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                         .WRITE_LATENCY(WL), .READ_LATENCY(RL)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_valid0(rv[0]), .i_valid1(rv[1]), .i_we0(rwe[0]), .i_we1(rwe[1]),
    .i_addr0(ra[0]), .i_addr1(ra[1]), .i_wdata0(rd[0]), .i_wdata1(rd[1]),
    .o_ready0(o_ready0), .o_ready1(o_ready1),
    .o_rvalid0(o_rvalid0), .o_rvalid1(o_rvalid1), .o_rdata(o_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_din(o_mem_din), .i_mem_dout(i_mem_dout), .o_busy(o_busy)
`ifdef LAT_MEM_ARB_STATS_EN
    , .o_grant_cnt0(gc0), .o_grant_cnt1(gc1), .o_stall_cnt(sc)
`endif
  );

  typedef struct {int g; logic [AW-1:0] addr;} wrh_t;
  typedef struct {int due; bit id; logic [DW-1:0] data;} rdq_t;
  typedef struct {int t; logic [AW-1:0] addr; logic [DW-1:0] data;} pw_t;
  typedef struct {int due; logic [DW-1:0] data;} dq_t;

  wrh_t wh[$];
  int   rh[$];
  rdq_t rq[$];
  pw_t  pend[$];
  dq_t  dq[$];
  logic [DW-1:0] arch [8];
  logic [DW-1:0] phys [8];

  int n_chk = 0, n_err = 0, cyc = 0, rr = 0;
  int st_g0 = 0, st_g1 = 0, st_st = 0;
  logic          pg_v = 1'b0, pg_we = 1'b0;
  logic [AW-1:0] pg_a = '0;
  logic [DW-1:0] pg_d = '0;
  logic [1:0]    obs_rdy, obs_rv;
  logic [DW-1:0] obs_rd;
  logic          obs_bsy;
  bit            gnt [2];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle: run the memory model, compare DUT against the reference, and
  // advance the reference by this cycle's grant.
  task automatic eval();
    logic hz [2];
    logic el [2];
    int eg;
    logic [1:0] exp_rv;
    logic [DW-1:0] exp_rd;
    logic exp_bsy;
    @(negedge i_clk);
    obs_rdy = {o_ready1, o_ready0};
    obs_rv  = {o_rvalid1, o_rvalid0};
    obs_rd  = o_rdata;
    obs_bsy = o_busy;
    for (int i = 0; i < pend.size(); ) begin
      if (pend[i].t <= cyc) begin
        phys[pend[i].addr] = pend[i].data;
        pend.delete(i);
      end else i++;
    end
    if (o_mem_en === 1'b1) begin
      if (o_mem_we) pend.push_back('{cyc + WL, o_mem_addr, o_mem_din});
      else dq.push_back('{cyc + RL, phys[o_mem_addr]});
    end
    gnt[0] = 0; gnt[1] = 0;
    if (i_rst_n !== 1'b1) begin
      chk("reset_outputs", 64'({obs_rdy, obs_rv, o_mem_en, o_mem_we, obs_bsy, obs_rd}), 64'd0);
      rq.delete(); wh.delete(); rh.delete();
      pg_v = 0; rr = 0; st_g0 = 0; st_g1 = 0; st_st = 0;
      return;
    end
    chk("mem_en", 64'(o_mem_en), 64'(pg_v));
    if (pg_v) chk("mem_cmd", 64'({o_mem_we, o_mem_addr, o_mem_din}), 64'({pg_we, pg_a, pg_d}));
    else      chk("mem_we_idle", 64'(o_mem_we), 64'd0);
    while (wh.size() > 0 && cyc - wh[0].g > WL) void'(wh.pop_front());
    while (rh.size() > 0 && cyc - rh[0] > RL + 1) void'(rh.pop_front());
    for (int n = 0; n < 2; n++) begin
      hz[n] = 0;
      if (rv[n] && !rwe[n]) begin
        foreach (wh[k])
          if (cyc - wh[k].g >= 1 && cyc - wh[k].g <= WL - 1 && wh[k].addr == ra[n]) hz[n] = 1;
        if (rv[1-n] && rwe[1-n] && ra[1-n] == ra[n]) hz[n] = 1;
      end
      el[n] = rv[n] && !hz[n];
    end
    eg = -1;
    if (el[0] && el[1]) eg = rr;
    else if (el[0]) eg = 0;
    else if (el[1]) eg = 1;
    chk("ready", 64'(obs_rdy), (eg < 0) ? 64'd0 : (64'd1 << eg));
    exp_rv = '0; exp_rd = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      exp_rv[rq[0].id] = 1'b1;
      exp_rd = rq[0].data;
      void'(rq.pop_front());
    end
    chk("rvalid", 64'(obs_rv), 64'(exp_rv));
    chk("rdata", 64'(obs_rd), 64'(exp_rd));
    exp_bsy = 0;
    foreach (wh[k]) if (cyc - wh[k].g >= 1 && cyc - wh[k].g <= WL) exp_bsy = 1;
    foreach (rh[k]) if (cyc - rh[k] >= 2 && cyc - rh[k] <= RL + 1) exp_bsy = 1;
    chk("busy", 64'(obs_bsy), 64'(exp_bsy));
    pg_v = (eg >= 0);
    if (eg >= 0) begin
      pg_we = rwe[eg]; pg_a = ra[eg]; pg_d = rd[eg];
      gnt[eg] = 1; rr = 1 - eg;
      if (eg == 0) st_g0++; else st_g1++;
      if (rwe[eg]) begin
        arch[ra[eg]] = rd[eg];
        wh.push_back('{cyc, ra[eg]});
      end else begin
        rq.push_back('{cyc + 1 + RL, eg[0], arch[ra[eg]]});
        rh.push_back(cyc);
      end
    end
    if (hz[0] || hz[1]) st_st++;
  endtask

  // Just after the edge: next cycle number and memory read data.
  task automatic adv();
    @(posedge i_clk);
    cyc++;
    #1;
    i_mem_dout = DW'($urandom);
    while (dq.size() > 0 && dq[0].due < cyc) void'(dq.pop_front());
    if (dq.size() > 0 && dq[0].due == cyc) i_mem_dout = dq.pop_front().data;
  endtask

  task automatic cyc_run();
    eval();
    adv();
  endtask

  task automatic new_req(int n);
    rv[n]  = ($urandom_range(0, 3) != 0);
    rwe[n] = ($urandom_range(0, 2) == 0);
    ra[n]  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(5, 7)) : AW'($urandom);
    rd[n]  = DW'($urandom);
  endtask

  // Issue one read from requester n, report cycles waited and data returned.
  task automatic rd_get(int n, logic [AW-1:0] addr, output logic [DW-1:0] data, output int waits);
    bit got = 0;
    rv[n] = 1; rwe[n] = 0; ra[n] = addr; waits = 0; data = '0;
    for (int k = 0; k < 30 && !got; k++) begin
      cyc_run();
      if (rv[n]) begin
        if (obs_rdy[n]) rv[n] = 0; else waits++;
      end else if (obs_rv[n]) begin
        data = obs_rd; got = 1;
      end
    end
    rv[n] = 0;
    chk("read_return_timeout", 64'(got), 64'd1);
  endtask

  task automatic idle(int n);
    rv[0] = 0; rv[1] = 0;
    repeat (n) cyc_run();
  endtask

  initial begin
    logic [DW-1:0] data;
    int waits;
    int order[$];
    i_rst_n = 0; i_mem_dout = '0;
    for (int i = 0; i < 8; i++) begin
      arch[i] = DW'($urandom);
      phys[i] = arch[i];
    end
    for (int n = 0; n < 2; n++) begin rwe[n] = 0; rd[n] = '0; end
    // reset held with both requesters asking
    rv[0] = 1; ra[0] = 3'd1; rv[1] = 1; ra[1] = 3'd2;
    repeat (3) cyc_run();
    // release: continuous contention on addr 1 / 2
    i_rst_n = 1;
    cyc_run();
    chk("first_grant_r0", 64'(obs_rdy), 64'd1);
    repeat (10) cyc_run();
    idle(RL + 3);
    // fresh reset, then read-after-write
    i_rst_n = 0; cyc_run(); i_rst_n = 1;
    idle(1);
    rv[0] = 1; rwe[0] = 1; ra[0] = 3'd3; rd[0] = 8'hA5;
    cyc_run();
    chk("raw_write_grant", 64'(obs_rdy), 64'd1);
    rv[0] = 0;
    rd_get(1, 3'd3, data, waits);
    chk("raw_stall_cycles", 64'(waits), 64'(WL - 1));
    chk("raw_data", 64'(data), 64'hA5);
`ifdef LAT_MEM_ARB_STATS_EN
    chk("stat_stall", 64'(sc), 64'(WL - 1));
    chk("stat_grant0", 64'(gc0), 64'd1);
    chk("stat_grant1", 64'(gc1), 64'd1);
    chk("stat_model", 64'({sc, gc0, gc1}), 64'({16'(st_st), 16'(st_g0), 16'(st_g1)}));
`endif
    idle(2);
    // non-conflicting write then read
    rv[0] = 1; rwe[0] = 1; ra[0] = 3'd3; rd[0] = 8'h5A;
    cyc_run();
    rv[0] = 0;
    rd_get(1, 3'd4, data, waits);
    chk("nc_stall_cycles", 64'(waits), 64'd0);
    idle(WL);
    // both read addr 7, then both write addr 0
    rv[0] = 1; rwe[0] = 0; ra[0] = 3'd7; rv[1] = 1; rwe[1] = 0; ra[1] = 3'd7;
    for (int k = 0; k < 4; k++) begin
      cyc_run();
      for (int n = 0; n < 2; n++) if (obs_rdy[n]) rv[n] = 0;
    end
    idle(RL + 2);
    rv[0] = 1; rwe[0] = 1; ra[0] = 3'd0; rd[0] = 8'h11;
    rv[1] = 1; rwe[1] = 1; ra[1] = 3'd0; rd[1] = 8'h22;
    for (int k = 0; k < 4; k++) begin
      cyc_run();
      for (int n = 0; n < 2; n++) if (obs_rdy[n]) begin rv[n] = 0; order.push_back(n); end
    end
    chk("ww_both_granted", 64'(order.size()), 64'd2);
    idle(WL);
    rd_get(0, 3'd0, data, waits);
    if (order.size() == 2) chk("ww_later_wins", 64'(data), 64'(rd[order[1]]));
    idle(2);
    // random traffic
    for (int k = 0; k < 400; k++) begin
      for (int n = 0; n < 2; n++) if (!rv[n] || gnt[n]) new_req(n);
      cyc_run();
    end
    idle(WL + RL + 3);
    // reset with two reads in flight
    rv[0] = 1; rwe[0] = 0; ra[0] = 3'd1;
    cyc_run();
    rv[0] = 0; rv[1] = 1; rwe[1] = 0; ra[1] = 3'd2;
    cyc_run();
    rv[1] = 0;
    i_rst_n = 0; cyc_run(); i_rst_n = 1;
    for (int k = 0; k < RL + 3; k++) begin
      cyc_run();
      chk("midreset_rvalid", 64'(obs_rv), 64'd0);
      chk("midreset_busy", 64'(obs_bsy), 64'd0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
